// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one wide-word BRAM wrapper port among NUM_REQ requesters.
// Define BRAM_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority instead of round robin.
module bram_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int ADDRS     = 1024,
    parameter int WIDTH     = 2048,
    localparam int ADDR_SIZE = $clog2(ADDRS)
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [NUM_REQ-1:0]           req_in,
    input  logic [NUM_REQ-1:0]           we_in,
    input  logic [NUM_REQ*ADDR_SIZE-1:0] addr_in,
    input  logic [NUM_REQ*WIDTH-1:0]     wdata_in,
    output logic [NUM_REQ-1:0]           gnt_out,
    output logic [NUM_REQ-1:0]           done_out,
    output logic [WIDTH-1:0]             rdata_out,
    output logic                         busy_out,
    output logic [ADDR_SIZE-1:0]         w_addr_out,
    output logic [WIDTH-1:0]             w_data_out,
    output logic                         w_we_out,
    input  logic [WIDTH-1:0]             w_data_in,
    input  logic                         w_finished_in
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP} state_t;

    state_t               state;
    state_t               next_state;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     owner;
    logic                 found;
    logic                 capture;
    logic                 cur_we;
    logic                 cur_hit;
    logic                 last_valid;
    logic [ADDR_SIZE-1:0] last_addr;
    logic [ADDR_SIZE-1:0] cap_addr;
    logic [WIDTH-1:0]     cap_data;
    logic                 cap_we;
    logic                 cap_hit;
    logic                 enter_resp;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]     last_ptr;
`endif

    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
            idx = i;
`else
            idx = (int'(last_ptr) + 1 + i) % NUM_REQ;
`endif
            if (!found && req_in[IDX_W'(idx)]) begin
                found  = 1'b1;
                winner = IDX_W'(idx);
            end
        end
    end

    assign cap_addr   = addr_in[int'(winner)*ADDR_SIZE +: ADDR_SIZE];
    assign cap_data   = wdata_in[int'(winner)*WIDTH +: WIDTH];
    assign cap_we     = we_in[winner];
    // A read of the address the wrapper already holds is answered from its output.
    assign cap_hit    = !cap_we && last_valid && (cap_addr == last_addr);
    assign capture    = (state == IDLE) && found && w_finished_in;
    assign enter_resp = (state != RESP) && (next_state == RESP);
    assign busy_out   = (state != IDLE);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (capture) next_state = ISSUE;
            ISSUE:      next_state = cur_hit ? RESP : WAIT_START;
            WAIT_START: next_state = WAIT_DONE;
            WAIT_DONE:  if (w_finished_in) next_state = RESP;
            RESP:       next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            owner      <= '0;
            cur_we     <= 1'b0;
            cur_hit    <= 1'b0;
            last_valid <= 1'b0;
            last_addr  <= '0;
            gnt_out    <= '0;
            done_out   <= '0;
            rdata_out  <= '0;
            w_addr_out <= '0;
            w_data_out <= '0;
            w_we_out   <= 1'b0;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
            last_ptr   <= IDX_W'(NUM_REQ - 1);
`endif
        end else begin
            w_we_out <= 1'b0;
            done_out <= '0;
            if (capture) begin
                owner   <= winner;
                cur_we  <= cap_we;
                cur_hit <= cap_hit;
                gnt_out <= {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
`ifndef BRAM_ARB_FIXED_PRIORITY_EN
                last_ptr <= winner;
`endif
                // The wrapper starts a read whenever its address changes, so only touch it on a real transfer.
                if (!cap_hit) begin
                    w_addr_out <= cap_addr;
                    last_addr  <= cap_addr;
                    last_valid <= 1'b1;
                end
                if (cap_we) begin
                    w_data_out <= cap_data;
                    w_we_out   <= 1'b1;
                end
            end
            if (enter_resp) begin
                done_out <= {{(NUM_REQ-1){1'b0}}, 1'b1} << owner;
                gnt_out  <= '0;
                if (!cur_we) begin
                    rdata_out <= w_data_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter with a behavioural BRAM wrapper and a done-driven scoreboard.
module tb_bram_arbiter;

    localparam int NR = 4;
    localparam int AD = 1024;
    localparam int W  = 64;
    localparam int AS = $clog2(AD);

    typedef struct {
        int             k;
        bit             rd;
        logic [W-1:0]   data;
    } exp_t;

    typedef struct {
        int             k;
        bit             we;
        int             addr;
        logic [W-1:0]   data;
        bit             hit;
        int             lat;
    } vec_t;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [NR-1:0]     req_in;
    logic [NR-1:0]     we_in;
    logic [NR*AS-1:0]  addr_in;
    logic [NR*W-1:0]   wdata_in;
    logic [NR-1:0]     gnt_out;
    logic [NR-1:0]     done_out;
    logic [W-1:0]      rdata_out;
    logic              busy_out;
    logic [AS-1:0]     w_addr_out;
    logic [W-1:0]      w_data_out;
    logic              w_we_out;
    logic [W-1:0]      w_data_in;
    logic              w_finished_in;

    int           checks = 0;
    int           errors = 0;
    int           lat = 1;
    logic         stall = 1'b0;
    exp_t         sb[$];
    logic [W-1:0] ref_mem [AD];
    logic [W-1:0] wmem [AD];
    logic [AS-1:0] tb_last_addr;
    logic         wfin;
    int           wcnt;
    logic [AS-1:0] wprev;
    logic         wrd;

    bram_arbiter #(.NUM_REQ(NR), .ADDRS(AD), .WIDTH(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .we_in(we_in),
        .addr_in(addr_in), .wdata_in(wdata_in), .gnt_out(gnt_out), .done_out(done_out),
        .rdata_out(rdata_out), .busy_out(busy_out), .w_addr_out(w_addr_out),
        .w_data_out(w_data_out), .w_we_out(w_we_out), .w_data_in(w_data_in),
        .w_finished_in(w_finished_in)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [W-1:0] pat(input int i);
        return {32'hC0DE_0000 + 32'(i), ~32'(i)};
    endfunction

    // Wrapper model: a write or an address change drops finished for lat cycles, then data appears.
    assign w_finished_in = wfin & ~stall;

    always @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wfin      <= 1'b1;
            wcnt      <= 0;
            wprev     <= '0;
            wrd       <= 1'b0;
            w_data_in <= '0;
            for (int i = 0; i < AD; i++) wmem[i] <= pat(i);
        end else begin
            wprev <= w_addr_out;
            if (w_we_out) begin
                wmem[w_addr_out] <= w_data_out;
                w_data_in <= w_data_out;
                wfin <= 1'b0;
                wcnt <= lat;
                wrd  <= 1'b0;
            end else if (w_addr_out != wprev) begin
                wfin <= 1'b0;
                wcnt <= lat;
                wrd  <= 1'b1;
            end else if (wcnt > 0) begin
                wcnt <= wcnt - 1;
                if (wcnt == 1) begin
                    wfin <= 1'b1;
                    if (wrd) w_data_in <= wmem[w_addr_out];
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every done pulse is matched against the oldest outstanding expectation.
    always @(negedge clk_in) begin
        exp_t e;
        if (!rst_in && done_out != '0) begin
            if (sb.size() == 0) begin
                checkOutput("done_unexpected", W'(done_out), '0);
            end else begin
                e = sb.pop_front();
                checkOutput("done", W'(done_out), W'(1) << e.k);
                checkOutput("gnt_clear_at_done", W'(gnt_out), '0);
                if (e.rd) checkOutput("rdata", rdata_out, e.data);
            end
        end
    end

    task automatic doReset();
        rst_in = 1'b1;
        sb.delete();
        for (int i = 0; i < AD; i++) ref_mem[i] = pat(i);
        tb_last_addr = '0;
        @(negedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    task automatic waitDone(input int exp_cycles);
        int cycles;
        cycles = 1;
        do begin
            @(negedge clk_in);
            cycles++;
        end while (done_out == '0 && cycles < 200);
        checkOutput("done_seen", W'(|done_out), W'(1));
        checkOutput("latency", W'(cycles), W'(exp_cycles));
        @(negedge clk_in);
        checkOutput("idle_after_resp", W'(busy_out), '0);
    endtask

    // Called at a negedge with the DUT idle; drives one request and follows it to completion.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        lat = v.lat;
        req_in[v.k] = 1'b1;
        we_in[v.k]  = v.we;
        addr_in[v.k*AS +: AS] = AS'(v.addr);
        wdata_in[v.k*W +: W]  = v.data;
        e.k = v.k;
        e.rd = !v.we;
        e.data = v.we ? '0 : ref_mem[v.addr];
        sb.push_back(e);
        if (v.we) ref_mem[v.addr] = v.data;
        @(negedge clk_in);
        checkOutput("gnt", W'(gnt_out), W'(1) << v.k);
        checkOutput("busy", W'(busy_out), W'(1));
        checkOutput("we_pulse", W'(w_we_out), W'(v.we));
        if (!v.hit) tb_last_addr = AS'(v.addr);
        checkOutput("w_addr", W'(w_addr_out), W'(tb_last_addr));
        if (v.we) checkOutput("w_data", w_data_out, v.data);
        req_in[v.k] = 1'b0;
        waitDone(v.hit ? 2 : 3 + v.lat);
    endtask

    vec_t vecs[9];
    int   exp_order[5];

    initial begin
        exp_t e;
        int   n;
        vecs[0] = '{k: 0, we: 1, addr: 3, data: {8{8'hA5}},        hit: 0, lat: 1};
        vecs[1] = '{k: 1, we: 0, addr: 7, data: '0,                hit: 0, lat: 1};
        vecs[2] = '{k: 3, we: 1, addr: 5, data: 64'h1234_5678_9ABC_DEF0, hit: 0, lat: 2};
        vecs[3] = '{k: 2, we: 0, addr: 5, data: '0,                hit: 1, lat: 1};
        vecs[4] = '{k: 1, we: 1, addr: 9, data: 64'hFEED_FACE_0BAD_F00D, hit: 0, lat: 1};
        vecs[5] = '{k: 0, we: 0, addr: 2, data: '0,                hit: 0, lat: 3};
        vecs[6] = '{k: 3, we: 0, addr: 9, data: '0,                hit: 0, lat: 1};
        vecs[7] = '{k: 2, we: 0, addr: 9, data: '0,                hit: 1, lat: 1};
        vecs[8] = '{k: 0, we: 0, addr: 0, data: '0,                hit: 0, lat: 1};
`ifdef BRAM_ARB_FIXED_PRIORITY_EN
        exp_order = '{0, 0, 0, 0, 0};
`else
        exp_order = '{0, 1, 2, 3, 0};
`endif
        rst_in = 1'b1;
        req_in = '0;
        we_in = '0;
        addr_in = '0;
        wdata_in = '0;
        #1;
        checkOutput("rst_gnt", W'(gnt_out), '0);
        checkOutput("rst_done", W'(done_out), '0);
        checkOutput("rst_rdata", rdata_out, '0);
        checkOutput("rst_busy", W'(busy_out), '0);
        checkOutput("rst_w_addr", W'(w_addr_out), '0);
        checkOutput("rst_w_data", w_data_out, '0);
        checkOutput("rst_w_we", W'(w_we_out), '0);
        doReset();

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // All requesters held high: grant order follows the pointer from reset.
        doReset();
        for (int k = 0; k < NR; k++) begin
            we_in[k] = 1'b0;
            addr_in[k*AS +: AS] = AS'(100 + k);
        end
        req_in = '1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            do begin
                @(negedge clk_in);
                n++;
            end while (gnt_out == '0 && n < 200);
            checkOutput($sformatf("rr_gnt%0d", g), W'(gnt_out), W'(1) << exp_order[g]);
            e.k = exp_order[g];
            e.rd = 1'b1;
            e.data = ref_mem[100 + exp_order[g]];
            sb.push_back(e);
            n = 0;
            do begin
                @(negedge clk_in);
                n++;
            end while (done_out == '0 && n < 200);
            checkOutput("rr_done_seen", W'(|done_out), W'(1));
        end
        req_in = '0;
        @(negedge clk_in);

        // Reset during WAIT_DONE, then the same address must be re-fetched as a miss.
        applyStimulus('{k: 1, we: 0, addr: 20, data: '0, hit: 0, lat: 1});
        lat = 10;
        req_in[1] = 1'b1;
        we_in[1] = 1'b1;
        addr_in[1*AS +: AS] = AS'(20);
        wdata_in[1*W +: W] = 64'h0F0F_0F0F_0F0F_0F0F;
        @(negedge clk_in);
        req_in[1] = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        checkOutput("mid_busy", W'(busy_out), W'(1));
        rst_in = 1'b1;
        #1;
        checkOutput("mid_rst_gnt", W'(gnt_out), '0);
        checkOutput("mid_rst_busy", W'(busy_out), '0);
        checkOutput("mid_rst_w_addr", W'(w_addr_out), '0);
        checkOutput("mid_rst_w_data", w_data_out, '0);
        checkOutput("mid_rst_rdata", rdata_out, '0);
        doReset();
        applyStimulus('{k: 1, we: 0, addr: 20, data: '0, hit: 0, lat: 1});

        // Wrapper holds finished low: no grant until it rises.
        doReset();
        stall = 1'b1;
        req_in[1] = 1'b1;
        we_in[1] = 1'b0;
        addr_in[1*AS +: AS] = AS'(50);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk_in);
            if (gnt_out != '0) n++;
        end
        checkOutput("stall_no_gnt", W'(n), '0);
        stall = 1'b0;
        e.k = 1;
        e.rd = 1'b1;
        e.data = ref_mem[50];
        sb.push_back(e);
        @(negedge clk_in);
        checkOutput("stall_gnt", W'(gnt_out), W'(2));
        req_in[1] = 1'b0;
        tb_last_addr = AS'(50);
        checkOutput("stall_w_addr", W'(w_addr_out), W'(tb_last_addr));
        waitDone(4);

        checkOutput("sb_empty", W'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
# bram_arbiter

Round-robin arbiter that shares one wide-word BRAM wrapper port among `NUM_REQ` requesters (weight loader, activation writer, layer sequencer, …). It latches one request at a time, drives the wrapper's address, data and write-enable lines, waits for the wrapper's `finished` handshake, then returns read data and a one-cycle `done` pulse to the winning requester. Same-address reads are served directly from the wrapper's held output without restarting a BRAM transfer.

## Interface
- `NUM_REQ`, 4, number of requesters (2..8).
- `ADDRS`, 1024, wide-word depth of the wrapped memory; `ADDR_SIZE = $clog2(ADDRS)`.
- `WIDTH`, 2048, wide-word width; equals wrapper `PIECES*BRAM_WIDTH`.
- `clk_in`  in  1  clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `req_in`  in  NUM_REQ  per-requester request level.
- `we_in`  in  NUM_REQ  per-requester write (1) / read (0).
- `addr_in`  in  NUM_REQ*ADDR_SIZE  packed request addresses, requester k at `[k*ADDR_SIZE +: ADDR_SIZE]`.
- `wdata_in`  in  NUM_REQ*WIDTH  packed write data, same packing.
- `gnt_out`  out  NUM_REQ  one-hot, high from capture until `done_out`.
- `done_out`  out  NUM_REQ  one-hot, one-cycle completion pulse.
- `rdata_out`  out  WIDTH  shared read data, valid in the `done_out` cycle of a read.
- `busy_out`  out  1  high whenever state is not IDLE.
- `w_addr_out`  out  ADDR_SIZE  wrapper address.
- `w_data_out`  out  WIDTH  wrapper write data.
- `w_we_out`  out  1  wrapper write enable (one-cycle pulse).
- `w_data_in`  in  WIDTH  wrapper data output.
- `w_finished_in`  in  1  wrapper finished flag.

## Operation
- States: IDLE, ISSUE, WAIT_START, WAIT_DONE, RESP.
- IDLE: if any `req_in` bit is set and `w_finished_in`=1, pick a winner k, latch `we_in[k]`, `addr_in[k]`, `wdata_in[k]`, set `gnt_out[k]`, and go to ISSUE. Requester k may drop `req_in` or change inputs after the grant.
- Round robin: search starts at (last granted + 1) mod NUM_REQ. Pointer resets to NUM_REQ-1, so requester 0 wins first.
- ISSUE, write: drive `w_addr_out`/`w_data_out`, pulse `w_we_out`=1 for this cycle only, then go to WAIT_START. Set last_addr=addr, last_valid=1.
- ISSUE, read with last_valid and addr==last_addr (hit): drive no BRAM transfer and go to RESP.
- ISSUE, read miss: drive `w_addr_out`=addr, then go to WAIT_START. Set last_addr=addr, last_valid=1.
- WAIT_START: one dead cycle while the wrapper deasserts `finished`. Then go to WAIT_DONE.
- WAIT_DONE: stay until `w_finished_in`=1, then go to RESP.
- RESP: register `rdata_out <= w_data_in` for reads; `rdata_out` holds for writes. Pulse `done_out[k]`, clear `gnt_out`, return to IDLE.
- `w_addr_out` holds the last issued address at all times outside ISSUE. Changing it would make the wrapper start a spurious read.
- `w_data_out` holds its last value.
- Requests raised while busy wait; there is no queueing beyond the `req_in` levels.

## Timing
- Reset values: `gnt_out`=0, `done_out`=0, `rdata_out`=0, `busy_out`=0, `w_addr_out`=0, `w_data_out`=0, `w_we_out`=0, state=IDLE, last_valid=0.
- Request seen in IDLE at cycle 0: `gnt_out` high at cycle 1 (ISSUE), `busy_out` high from cycle 1.
- Hit read: `done_out` and `rdata_out` at cycle 2.
- Miss or write: `done_out` one cycle after the first cycle with `w_finished_in`=1 in WAIT_DONE. Minimum is cycle 4.
- Simultaneous requests resolve in the same cycle.
- Winner k gets `done_out[k]` and may re-request. It cannot win again while other requests are pending (round robin).
- `done_out` and a new grant are never in the same cycle; IDLE always follows RESP.
- Reset asserted mid-operation: return to the reset values immediately. The wrapper must be reset in the same cycle; there is no partial-write recovery.
- IDLE with `w_finished_in`=0 (wrapper still busy after reset): no grant is issued.

## Configuration
- `BRAM_ARB_FIXED_PRIORITY_EN`:
  - Defined: fixed priority, lowest index wins; the round-robin pointer is removed.
  - Undefined: round robin as above.

## Test plan
- Reset, then req0 writes 0xA5..A5 to addr 3: `w_we_out` pulses at cycle 1 with addr 3, then `done_out`=0001. Req1 then reads addr 7 (miss): `w_addr_out`=7 and `done_out`=0010 after the wrapper finishes.
- After a write of X to addr 5, req2 reads addr 5: hit, no `w_addr_out` change, `done_out`=0100 at cycle 2, `rdata_out`=X.
- req0..req3 all held high continuously: grants in order 0,1,2,3,0. With `BRAM_ARB_FIXED_PRIORITY_EN`, req0 wins every time.
- Write addr 9=Y, then read addr 2, then read addr 9 (miss): `rdata_out`=Y.
- Assert `rst_in` during WAIT_DONE: all outputs are 0 in the same cycle. The next read of the last address is treated as a miss.
- Hold `w_finished_in`=0 for 40 cycles after reset with req1 high: no grant. Grant follows 1 cycle after `finished` rises.
